hack_rom_loader: RTL and testbench
==================================

# hack_rom_loader

Boot-time program loader sitting directly upstream of the Hack CPU's instruction port. Consumes a framed byte stream from the UART receiver, assembles big-endian 16-bit instruction words, writes them into the instruction ROM, and verifies an XOR checksum. Holds the CPU in reset until a complete, valid image has been written.

## Interface
- ADDR_W, 15, instruction ROM address width; DEPTH = 2^ADDR_W words
- SYNC, 8'hA5, frame start byte
- clk  in  1  clock
- rstn  in  1  reset, synchronous, active-low
- rx_data  in  8  byte from UART receiver
- rx_valid  in  1  rx_data valid
- rx_ready  out  1  loader accepts byte; transfer when rx_valid & rx_ready
- rom_we  out  1  ROM write strobe, one cycle per word
- rom_waddr  out  ADDR_W  ROM write address (word index)
- rom_wdata  out  16  ROM write data
- cpu_rstn  out  1  drives CPU rstn; 0 = CPU held in reset
- loaded  out  1  1 while in RUN
- error  out  1  1 while in ERROR

## Operation
- Frame: SYNC, LEN_H, LEN_L, then N words as (hi byte, lo byte), then CSUM. N = {LEN_H, LEN_L}. CSUM = XOR of all 2N data bytes (length bytes excluded).
- States: SYNC_WAIT, LEN_H, LEN_L, DATA_H, DATA_L, WRITE, CSUM, RUN, ERROR.
- SYNC_WAIT: accept byte; SYNC -> LEN_H, clear checksum and word index; other bytes discarded.
- LEN_H / LEN_L: latch length bytes. After LEN_L: N == 0 or N > DEPTH -> ERROR, else DATA_H.
- DATA_H: latch high byte, XOR into checksum -> DATA_L.
- DATA_L: latch low byte, XOR into checksum -> WRITE.
- WRITE: rom_we=1, rx_ready=0, rom_waddr = index, rom_wdata = {hi, lo}. Index == N-1 -> CSUM, else index+1 and -> DATA_H.
- CSUM: accept byte; match -> RUN, mismatch -> ERROR.
- RUN: cpu_rstn=1. Accepts and discards bytes; SYNC byte -> LEN_H (reload; CPU re-enters reset).
- ERROR: cpu_rstn=0, error=1. SYNC byte -> LEN_H, error clears.
- rx_ready = 1 in every state except WRITE.
- ROM contents written before a checksum failure are left as-is; only CPU release is gated.

## Timing
- Reset values: state SYNC_WAIT, rom_we 0, rom_waddr 0, rom_wdata 0, cpu_rstn 0, loaded 0, error 0, checksum 0, index 0.
- All outputs are registered except rx_ready, which is a decode of the current state.
- One byte per cycle maximum; each word costs at least 3 cycles (DATA_H, DATA_L, WRITE).
- rom_we is asserted for exactly one cycle per word, during WRITE; rom_waddr and rom_wdata are stable in that cycle.
- cpu_rstn rises in the cycle after the matching CSUM byte is accepted; loaded rises the same cycle.
- A SYNC byte accepted in RUN drops cpu_rstn and loaded the next cycle.
- A SYNC byte inside DATA_H/DATA_L/LEN_* is treated as data, not a resync.
- rx_valid low stalls any state indefinitely, with no timeout.
- rstn low at any point, including mid-frame or mid-WRITE, returns all state to reset values on the next edge; the frame is abandoned.
- N == DEPTH is legal: the last write is to index DEPTH-1, with no index wrap.

## Structure
- Shared package hack_loader_pkg holds the state encoding localparams, SYNC default, and the frame field order.
- Single module. No sub-module; byte assembly and checksum are a few registers inside the FSM.
- Top level wires rom_we/rom_waddr/rom_wdata into the ROM write port, and cpu_rstn AND rstn into the CPU rstn. The CPU's pc drives the ROM read port directly.

## Test plan
- Happy path: A5 00 02 12 34 AB CD 40, one byte per cycle -> writes 0x1234@0 and 0xABCD@1; cpu_rstn=1, loaded=1 one cycle after CSUM byte.
- Bad checksum: same frame with CSUM 41 -> both words written; error=1; cpu_rstn stays 0. Then resend the good frame -> RUN, error=0.
- Length limits: A5 00 00 -> ERROR right after LEN_L; with ADDR_W=4, A5 00 11 -> ERROR; A5 00 10 plus 16 words -> last write at address 15, then RUN.
- Backpressure and gaps: random rx_valid gaps; check rx_ready=0 exactly in WRITE cycles, no byte is lost or duplicated, and rom_we pulses exactly N times.
- Reload and noise: garbage bytes 00 FF before SYNC are ignored; in RUN, bytes 11 22 are ignored; A5 -> cpu_rstn=0 next cycle and a new frame loads.
- Reset mid-frame: assert rstn after DATA_H of word 1 -> all outputs return to reset values; a following complete frame loads correctly from index 0.

Source files
------------

// File: rtl/hack_loader_pkg.sv
// Shared definitions for the Hack boot loader: FSM state encoding, default
// frame sync byte and the length-field bounds helper.
package hack_loader_pkg;

    typedef enum logic [3:0] {
        ST_SYNC_WAIT = 4'd0,
        ST_LEN_H     = 4'd1,
        ST_LEN_L     = 4'd2,
        ST_DATA_H    = 4'd3,
        ST_DATA_L    = 4'd4,
        ST_WRITE     = 4'd5,
        ST_CSUM      = 4'd6,
        ST_RUN       = 4'd7,
        ST_ERROR     = 4'd8
    } state_t;

    localparam logic [7:0] SYNC_DEFAULT = 8'hA5;

    // Frame layout on the wire: SYNC, LEN_H, LEN_L, N x (DATA_H, DATA_L), CSUM.
    localparam int LEN_W = 16;

    // A length is usable when it names at least one word and fits the ROM.
    function automatic logic len_ok(input logic [LEN_W-1:0] n, input int addr_w);
        logic [LEN_W:0] depth;
        depth = (LEN_W+1)'(1) << addr_w;
        return (n != '0) && ({1'b0, n} <= depth);
    endfunction

endpackage

// File: rtl/hack_rom_loader.sv
// Framed UART byte stream -> instruction ROM writes with XOR checksum; holds CPU in reset until valid.
// Registered outputs (rx_ready is a state decode); rx_ready drops only in the one-cycle WRITE state.
module hack_rom_loader
    import hack_loader_pkg::*;
#(
    parameter int         ADDR_W = 15,
    parameter logic [7:0] SYNC   = SYNC_DEFAULT
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              rom_we,
    output logic [ADDR_W-1:0] rom_waddr,
    output logic [15:0]       rom_wdata,
    output logic              cpu_rstn,
    output logic              loaded,
    output logic              error
);

    state_t              state;
    state_t              next_state;
    logic [LEN_W-1:0]    len_q;
    logic [7:0]          hi_q;
    logic [7:0]          csum_q;
    logic [ADDR_W-1:0]   index_q;
    logic                accept;
    logic                last_word;
    logic                start;

    assign accept    = rx_valid && rx_ready;
    assign last_word = (LEN_W'(index_q) == len_q - LEN_W'(1));
    assign start     = (state == ST_SYNC_WAIT || state == ST_RUN || state == ST_ERROR)
                       && (next_state == ST_LEN_H);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state <= ST_SYNC_WAIT;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            ST_SYNC_WAIT: if (accept && rx_data == SYNC) next_state = ST_LEN_H;
            ST_LEN_H:     if (accept) next_state = ST_LEN_L;
            ST_LEN_L: begin
                if (accept) begin
                    next_state = len_ok({len_q[15:8], rx_data}, ADDR_W) ? ST_DATA_H : ST_ERROR;
                end
            end
            ST_DATA_H:    if (accept) next_state = ST_DATA_L;
            ST_DATA_L:    if (accept) next_state = ST_WRITE;
            ST_WRITE:     next_state = last_word ? ST_CSUM : ST_DATA_H;
            ST_CSUM: begin
                if (accept) next_state = (rx_data == csum_q) ? ST_RUN : ST_ERROR;
            end
            ST_RUN, ST_ERROR: if (accept && rx_data == SYNC) next_state = ST_LEN_H;
            default:      next_state = ST_SYNC_WAIT;
        endcase
    end

    always_comb begin
        rx_ready = (state != ST_WRITE);
    end

    // Status outputs are registered from next_state so they line up with the state itself.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            rom_we    <= 1'b0;
            rom_waddr <= '0;
            rom_wdata <= '0;
            cpu_rstn  <= 1'b0;
            loaded    <= 1'b0;
            error     <= 1'b0;
            len_q     <= '0;
            hi_q      <= '0;
            csum_q    <= '0;
            index_q   <= '0;
        end else begin
            rom_we   <= (next_state == ST_WRITE);
            cpu_rstn <= (next_state == ST_RUN);
            loaded   <= (next_state == ST_RUN);
            error    <= (next_state == ST_ERROR);

            if (start) begin
                csum_q  <= '0;
                index_q <= '0;
            end

            unique case (state)
                ST_LEN_H: if (accept) len_q[15:8] <= rx_data;
                ST_LEN_L: if (accept) len_q[7:0]  <= rx_data;
                ST_DATA_H: begin
                    if (accept) begin
                        hi_q   <= rx_data;
                        csum_q <= csum_q ^ rx_data;
                    end
                end
                ST_DATA_L: begin
                    if (accept) begin
                        csum_q    <= csum_q ^ rx_data;
                        rom_waddr <= index_q;
                        rom_wdata <= {hi_q, rx_data};
                    end
                end
                ST_WRITE: if (!last_word) index_q <= index_q + ADDR_W'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_hack_rom_loader.sv
// Scoreboard bench for hack_rom_loader with a 16-word ROM.
module tb_hack_rom_loader;

    localparam int ADDR_W = 4;

    logic              clk = 1'b0;
    logic              rstn = 1'b0;
    logic [7:0]        rx_data = 8'h00;
    logic              rx_valid = 1'b0;
    logic              rx_ready;
    logic              rom_we;
    logic [ADDR_W-1:0] rom_waddr;
    logic [15:0]       rom_wdata;
    logic              cpu_rstn;
    logic              loaded;
    logic              error;

    always #5 clk = ~clk;

    hack_rom_loader #(.ADDR_W(ADDR_W), .SYNC(8'hA5)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .rom_we    (rom_we),
        .rom_waddr (rom_waddr),
        .rom_wdata (rom_wdata),
        .cpu_rstn  (cpu_rstn),
        .loaded    (loaded),
        .error     (error)
    );

    int                    n_checks = 0;
    int                    n_errors = 0;
    int                    n_writes = 0;
    int                    n_exp_writes = 0;
    logic [ADDR_W+15:0]    exp_q[$];
    bit                    gaps_on = 1'b0;
    logic [15:0]           frame_w[0:31];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Every cycle: rx_ready low exactly while a write is in flight; writes match the scoreboard.
    always @(negedge clk) begin
        logic [ADDR_W+15:0] e;
        check("rdy_vs_we", 32'(rx_ready), 32'(!rom_we));
        if (rom_we) begin
            n_writes++;
            check("write_pending", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("rom_waddr", 32'(rom_waddr), 32'(e[ADDR_W+15:16]));
                check("rom_wdata", 32'(rom_wdata), 32'(e[15:0]));
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int gap;
        int waited;
        gap = gaps_on ? int'($urandom_range(0, 2)) : 0;
        repeat (gap) @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        waited   = 0;
        while (!rx_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!rx_ready) check("rx_ready_timeout", 32'(rx_ready), 32'd1);
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic send_frame(input int n, input bit skip_sync, input logic [7:0] csum_flip);
        logic [7:0]  cs;
        logic [15:0] nn;
        logic [15:0] w;
        cs = 8'h00;
        nn = 16'(n);
        if (!skip_sync) send_byte(8'hA5);
        send_byte(nn[15:8]);
        send_byte(nn[7:0]);
        for (int i = 0; i < n; i++) begin
            w = frame_w[i];
            send_byte(w[15:8]);
            cs ^= w[15:8];
            exp_q.push_back({ADDR_W'(i), w});
            n_exp_writes++;
            send_byte(w[7:0]);
            cs ^= w[7:0];
        end
        check("pre_csum_cpu_rstn", 32'(cpu_rstn), 32'd0);
        send_byte(cs ^ csum_flip);
    endtask

    task automatic expect_status(input string tag, input logic c, input logic l, input logic e);
        check({tag, "_cpu_rstn"}, 32'(cpu_rstn), 32'(c));
        check({tag, "_loaded"},   32'(loaded),   32'(l));
        check({tag, "_error"},    32'(error),    32'(e));
    endtask

    task automatic expect_reset_outputs(input string tag);
        check({tag, "_rom_we"},    32'(rom_we),    32'd0);
        check({tag, "_rom_waddr"}, 32'(rom_waddr), 32'd0);
        check({tag, "_rom_wdata"}, 32'(rom_wdata), 32'd0);
        check({tag, "_rx_ready"},  32'(rx_ready),  32'd1);
        expect_status(tag, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic fill_random(input int n);
        for (int i = 0; i < n; i++) frame_w[i] = 16'($urandom);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        expect_reset_outputs("reset");
        rstn = 1'b1;

        // Noise before sync is ignored.
        send_byte(8'h00);
        send_byte(8'hFF);
        expect_status("noise", 1'b0, 1'b0, 1'b0);

        // Happy path, one byte per cycle.
        frame_w[0] = 16'h1234;
        frame_w[1] = 16'hABCD;
        send_frame(2, 1'b0, 8'h00);
        expect_status("happy", 1'b1, 1'b1, 1'b0);
        check("happy_drain", 32'(exp_q.size()), 32'd0);

        // Bytes in RUN are discarded; SYNC re-enters reset on the next cycle.
        send_byte(8'h11);
        send_byte(8'h22);
        expect_status("run_noise", 1'b1, 1'b1, 1'b0);
        send_byte(8'hA5);
        expect_status("reload_sync", 1'b0, 1'b0, 1'b0);
        gaps_on = 1'b1;
        fill_random(5);
        send_frame(5, 1'b1, 8'h00);
        expect_status("reload", 1'b1, 1'b1, 1'b0);
        gaps_on = 1'b0;

        // Bad checksum: words still written, CPU stays in reset.
        frame_w[0] = 16'h1234;
        frame_w[1] = 16'hABCD;
        send_frame(2, 1'b0, 8'h01);
        expect_status("bad_csum", 1'b0, 1'b0, 1'b1);
        check("bad_csum_drain", 32'(exp_q.size()), 32'd0);
        send_frame(2, 1'b0, 8'h00);
        expect_status("recover", 1'b1, 1'b1, 1'b0);

        // Length bounds.
        send_byte(8'hA5);
        send_byte(8'h00);
        send_byte(8'h00);
        expect_status("len_zero", 1'b0, 1'b0, 1'b1);
        send_byte(8'hA5);
        send_byte(8'h00);
        send_byte(8'h11);
        expect_status("len_over", 1'b0, 1'b0, 1'b1);
        gaps_on = 1'b1;
        fill_random(16);
        send_frame(16, 1'b0, 8'h00);
        expect_status("len_full", 1'b1, 1'b1, 1'b0);
        gaps_on = 1'b0;

        // Reset after the high byte of word 1.
        send_byte(8'hA5);
        send_byte(8'h00);
        send_byte(8'h02);
        send_byte(8'h12);
        exp_q.push_back({ADDR_W'(0), 16'h1234});
        n_exp_writes++;
        send_byte(8'h34);
        send_byte(8'hAB);
        rstn = 1'b0;
        @(negedge clk);
        expect_reset_outputs("mid_reset");
        rstn = 1'b1;
        fill_random(3);
        send_frame(3, 1'b0, 8'h00);
        expect_status("after_reset", 1'b1, 1'b1, 1'b0);

        repeat (2) @(negedge clk);
        check("final_drain", 32'(exp_q.size()), 32'd0);
        check("write_count", 32'(n_writes), 32'(n_exp_writes));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
